// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with single-outstanding imem handshake, 1-entry skid and IF/ID register.
// Optional perf counters (stall_cycles, flush_count) are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] pc_plus4_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
  logic [31:0] pc_id_q, pc_id_d, instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic        accept, deliver;
  logic [31:0] del_pc, del_instr;
  logic        unused_bits;
  assign unused_bits = ^branch_target[1:0];
  assign imem_req    = (state_q == REQ) && !flush;
  assign imem_addr   = pc_q;
  assign accept      = imem_req && imem_ready;
  assign pc_ID       = pc_id_q;
  assign pc_plus4_ID = pc_id_q + 32'd4;
  assign instr_ID    = instr_id_q;
  assign valid_ID    = valid_id_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    deliver      = 1'b0;
    del_pc       = skid_pc_q;
    del_instr    = skid_instr_q;
    case (state_q)
      REQ: if (accept) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        if (flush) state_d = REQ;
        else if (stall_IFID) begin
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem_rdata;
          state_d      = HOLD;
        end else begin
          deliver   = 1'b1;
          del_pc    = req_pc_q;
          del_instr = imem_rdata;
          state_d   = REQ;
        end
      end else if (flush) state_d = DROP;
      HOLD: if (flush || !stall_IFID) begin
        deliver = !flush;
        state_d = REQ;
      end
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = REQ;
    endcase
    // a redirect always wins; stale skid contents are simply never read again
    if (flush) pc_d = {branch_target[31:2], 2'b00};
    pc_id_d    = deliver ? del_pc : pc_id_q;
    instr_id_d = deliver ? del_instr : (stall_IFID && !flush) ? instr_id_q : NOP_INSTR;
    valid_id_d = deliver || (stall_IFID && !flush && valid_id_q);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      pc_id_q      <= '0;
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_IFID && !flush};
    flush_cnt_d = flush_cnt_q + {31'd0, flush};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized + directed bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0;
  logic stall_IFID = 1'b0, flush = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] branch_target = '0, imem_rdata = '0;
  logic imem_req, valid_ID;
  logic [31:0] imem_addr, pc_ID, pc_plus4_ID, instr_ID, stall_cycles, flush_count;
  fetch_stage dut (
    .clock(clock), .reset(reset), .stall_IFID(stall_IFID), .flush(flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_ID(pc_ID), .pc_plus4_ID(pc_plus4_ID), .instr_ID(instr_ID), .valid_ID(valid_ID),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clock = ~clock;
  int unsigned n_vec = 0, n_bad = 0;
  int fix_lat = 0;
  // model: next fetch pc, one outstanding fetch (maybe stale), one parked instruction, IF/ID contents
  logic [31:0] m_pc, m_out_pc, m_park_pc, m_park_ins, e_pc, e_ins, e_stall, e_flush;
  logic m_busy, m_stale, m_park_v, e_v;
  logic r_pend;
  logic [31:0] r_addr;
  int r_cnt;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1234};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_init();
    m_pc = 32'h0; m_busy = 0; m_stale = 0; m_park_v = 0;
    e_pc = 32'h0; e_ins = NOP; e_v = 0; e_stall = 0; e_flush = 0; r_pend = 0; r_cnt = 0;
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 0; stall_IFID = 0; flush = 0; imem_ready = 0; imem_rvalid = 0;
    #1;
    chk("rst_pc_ID", pc_ID, 32'h0);
    chk("rst_pc4_ID", pc_plus4_ID, 32'h4);
    chk("rst_instr_ID", instr_ID, NOP);
    chk("rst_valid_ID", {31'd0, valid_ID}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'h1);
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_flush_count", flush_count, 32'h0);
    model_init();
    @(negedge clock);
    reset = 1;
  endtask
  task automatic step(input logic st, input logic fl, input logic [31:0] tg, input logic rd);
    logic exp_req, dv;
    logic [31:0] dpc, dins, apc;
    @(negedge clock);
    chk("pc_ID", pc_ID, e_pc);
    chk("pc_plus4_ID", pc_plus4_ID, e_pc + 32'd4);
    chk("instr_ID", instr_ID, e_ins);
    chk("valid_ID", {31'd0, valid_ID}, {31'd0, e_v});
    chk("stall_cycles", stall_cycles, PERF ? e_stall : 32'h0);
    chk("flush_count", flush_count, PERF ? e_flush : 32'h0);
    stall_IFID = st; flush = fl; branch_target = tg; imem_ready = rd;
    imem_rvalid = r_pend && r_cnt == 0;
    imem_rdata = imem_rvalid ? mem(r_addr) : $urandom;
    #1;
    exp_req = !m_busy && !m_park_v && !fl;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("imem_addr", imem_addr, m_pc);
    dv = 0; dpc = '0; dins = '0; apc = m_pc;
    if (imem_rvalid && m_busy) begin
      m_busy = 0;
      if (!m_stale && !fl) begin
        if (st) begin m_park_v = 1; m_park_pc = m_out_pc; m_park_ins = imem_rdata; end
        else begin dv = 1; dpc = m_out_pc; dins = imem_rdata; end
      end
    end else if (m_park_v && !st && !fl) begin
      dv = 1; dpc = m_park_pc; dins = m_park_ins; m_park_v = 0;
    end
    if (fl) m_park_v = 0;
    if (exp_req && rd) begin m_busy = 1; m_stale = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4; end
    if (fl) begin
      if (m_busy) m_stale = 1;
      m_pc = tg & 32'hFFFF_FFFC;
    end
    if (fl) begin e_v = 0; e_ins = NOP; end
    else if (dv) begin e_v = 1; e_ins = dins; e_pc = dpc; end
    else if (!st) begin e_v = 0; e_ins = NOP; end
    if (fl) e_flush++;
    else if (st) e_stall++;
    if (imem_rvalid) r_pend = 0;
    else if (r_pend) r_cnt--;
    if (exp_req && rd) begin
      r_pend = 1; r_addr = apc;
      r_cnt = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 2));
    end
  endtask
  task automatic drain();
    repeat (4) step(0, 0, 32'h0, 0);
  endtask
  initial begin
    model_init();
    do_reset();
    fix_lat = 0;
    repeat (8) step(0, 0, 32'h0, 1);
    drain();
    step(0, 0, 32'h0, 1);
    repeat (3) step(1, 0, 32'h0, 1);
    repeat (4) step(0, 0, 32'h0, 1);
    fix_lat = 1;
    drain();
    step(0, 0, 32'h0, 1);
    step(0, 1, 32'h103, 1);
    repeat (6) step(0, 0, 32'h0, 1);
    fix_lat = 0;
    drain();
    step(0, 0, 32'h0, 1);
    step(0, 1, 32'h200, 1);
    repeat (2) step(0, 0, 32'h0, 1);
    step(1, 1, 32'h300, 1);
    repeat (4) step(0, 0, 32'h0, 1);
    drain();
    step(0, 1, 32'hFFFF_FFFC, 0);
    repeat (5) step(0, 0, 32'h0, 1);
    fix_lat = 1;
    drain();
    step(0, 0, 32'h0, 1);
    do_reset();
    repeat (5) step(1, 0, 32'h0, 0);
    repeat (2) step(0, 1, 32'h40, 0);
    @(negedge clock);
    chk("stall_cycles_5", stall_cycles, PERF ? 32'd5 : 32'd0);
    chk("flush_count_2", flush_count, PERF ? 32'd2 : 32'd0);
    stall_IFID = 0; flush = 0; imem_ready = 0; imem_rvalid = 0;
    fix_lat = -1;
    repeat (3000) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, tg, $urandom_range(0, 9) < 7);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register. Sits directly upstream of the hazard unit and consumes its stall_IFID and flush outputs.
- Owns the PC and talks to instruction memory through a request/response handshake with at most one request outstanding.
- Parks a returned instruction in a 1-entry skid buffer when ID is stalled.
- Redirects to the branch target on flush and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in instr_ID when not valid

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- stall_IFID  in  1  hold IF/ID contents and PC (from hazard unit)
- flush  in  1  branch taken: redirect PC, bubble IF/ID (from hazard unit)
- branch_target  in  32  redirect address, valid when flush=1
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; in order, latency >=1 cycle after accept
- imem_rdata  in  32  response instruction
- pc_ID  out  32  PC of instruction in IF/ID
- pc_plus4_ID  out  32  pc_ID+4
- instr_ID  out  32  instruction in IF/ID
- valid_ID  out  1  IF/ID holds a real instruction
- stall_cycles  out  32  perf counter (see Optional Feature)
- flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset values (reset low):
  - pc=RESET_PC; state=REQ; skid buffer empty.
  - pc_ID=0, pc_plus4_ID=4, instr_ID=NOP_INSTR, valid_ID=0; counters=0.
- imem_addr=pc at all times. imem_req=(state==REQ) && !flush, so it is combinational on flush.
- REQ state:
  - Accept = imem_req && imem_ready. On accept: req_pc<=pc; pc<=pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0); go to WAIT.
- WAIT state:
  - imem_req=0.
  - On imem_rvalid with stall_IFID=0: IF/ID <= {req_pc, imem_rdata, valid=1}; go to REQ.
  - On imem_rvalid with stall_IFID=1: skid <= {req_pc, imem_rdata}; go to HOLD.
- HOLD state:
  - imem_req=0. IF/ID is held while stall_IFID=1.
  - When stall_IFID=0: IF/ID <= skid with valid=1; skid emptied; go to REQ.
- DROP state:
  - imem_req=0. Wait for imem_rvalid, discard imem_rdata, then go to REQ.
- IF/ID update when no instruction is delivered this cycle:
  - stall_IFID=1: hold all IF/ID outputs.
  - Otherwise: load bubble (valid_ID=0, instr_ID=NOP_INSTR, pc fields hold previous value).
- Latency: first instruction appears in IF/ID one cycle after the imem_rvalid cycle. Zero-wait memory gives throughput of one instruction per 2 cycles (single outstanding).
- Flush has highest priority over stall and over every state transition:
  - pc <= {branch_target[31:2], 2'b00}; IF/ID <= bubble; skid emptied.
  - From REQ: no accept this cycle (imem_req forced low); stay in REQ.
  - From WAIT with imem_rvalid=0: go to DROP.
  - From WAIT with imem_rvalid=1: discard the response; go to REQ.
  - From HOLD: go to REQ.
  - From DROP: go to DROP if imem_rvalid=0; go to REQ if imem_rvalid=1 (response discarded).
- Simultaneous flush and stall_IFID: flush wins, and the IF/ID bubble is written despite the stall.
- imem_rvalid outside WAIT/DROP is a protocol error and is ignored.
- Reset asserted mid-transaction clears all state immediately. Instruction memory shares the same reset, so no response may arrive after reset release without a new request.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with stall_IFID=1 and flush=0.
  - flush_count increments on every cycle with flush=1.
  - Both counters are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: no counter registers are built; both ports are tied to 32'h0.

Test Plan:
- Reset release with imem_ready=1 and fixed 1-cycle latency -> addresses 0x0,0x4,0x8 requested; valid_ID pulses with pc_ID=0x0,0x4,0x8; instr_ID matches memory; bubble (NOP, valid 0) between instructions.
- stall_IFID=1 for 3 cycles while a response arrives -> IF/ID holds its old instruction and the new one is parked in skid. After the stall drops, the parked instruction appears the next cycle, with no imem_req during HOLD.
- flush with branch_target=0x103 while in WAIT (response 2 cycles later) -> the late response is discarded, the next imem_addr=0x100, and valid_ID=0 until the 0x100 instruction arrives.
- flush and imem_rvalid in the same cycle; separately flush and stall_IFID together -> the response is discarded, IF/ID becomes a bubble, and pc=target.
- PC at 0xFFFFFFFC accepted -> next imem_addr=0x00000000.
- reset driven low during WAIT -> outputs return to reset values immediately. With FETCH_PERF_CNT_EN, 5 stall cycles and 2 flushes -> stall_cycles=5, flush_count=2; without the macro, both stay 0.
